// File: rtl/burst_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | burst_rr_arbiter: round-robin arbiter granting bursts of up to BURST_LEN   |
// | words from one FWFT source into a single registered output stage.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module burst_rr_arbiter #(
   parameter int WIDTH  = 10,
   parameter int DATA_W = 32
) (
   input  logic                    BUS_CLK,
   input  logic                    BUS_RST,
   input  logic [WIDTH-1:0]        WRITE_REQ,
   input  logic [WIDTH-1:0]        HOLD_REQ,
   input  logic [WIDTH*DATA_W-1:0] DATA_IN,
   input  logic [7:0]              BURST_LEN,
   output logic [WIDTH-1:0]        READ_GRANT,
   input  logic                    READY_OUT,
   output logic                    WRITE_OUT,
   output logic [DATA_W-1:0]       DATA_OUT,
   output logic [3:0]              OWNER,
   output logic                    BUSY
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_owner;
   logic [3:0]          w_pick;
   logic [3:0]          w_scan;
   logic                w_found;
   logic [8:0]          r_cnt;
   logic [8:0]          r_len;
   logic [8:0]          w_cnt_nxt;
   logic                w_pop;
   logic                w_release;
   logic                w_own_req;
   logic                w_own_hold;
   logic                r_wout;
   logic [DATA_W-1:0]   r_dout;
   logic [DATA_W-1:0]   w_src [WIDTH];

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      assign w_src[gi] = DATA_IN[gi*DATA_W +: DATA_W];
   end

   assign w_own_req  = WRITE_REQ[r_owner];
   assign w_own_hold = HOLD_REQ[r_owner];

   // Scan downward in distance so the nearest requester after r_owner wins.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_owner;
      w_scan  = '0;
      for (int k = WIDTH; k >= 1; k--) begin
         w_scan = 4'((int'(r_owner) + k) % WIDTH);
         if (WRITE_REQ[w_scan]) begin
            w_found = 1'b1;
            w_pick  = w_scan;
         end
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_release   = 1'b0;
      w_cnt_nxt   = r_cnt;
      READ_GRANT  = '0;
      case (r_state)
         S_IDLE: begin
            if (w_found) w_state_nxt = S_BURST;
         end
         S_BURST: begin
            // No pop in a reset cycle, so sources keep their words.
            w_pop = !BUS_RST && w_own_req && (!r_wout || READY_OUT) &&
                    (w_own_hold || (r_cnt < r_len));
            if (w_pop && (r_cnt != 9'd255)) w_cnt_nxt = r_cnt + 9'd1;
            READ_GRANT[r_owner] = w_pop;
            // >= rather than == so a hold that ran past the limit still releases.
            w_release = !w_own_hold && (!w_own_req || (w_cnt_nxt >= r_len));
            if (w_release) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         r_owner <= 4'(WIDTH - 1);
         r_len   <= 9'd1;
         r_cnt   <= '0;
         r_wout  <= 1'b0;
         r_dout  <= '0;
      end else begin
         if ((r_state == S_IDLE) && w_found) begin
            r_owner <= w_pick;
            r_len   <= (BURST_LEN == 8'd0) ? 9'd1 : {1'b0, BURST_LEN};
            r_cnt   <= '0;
         end else begin
            r_cnt   <= w_cnt_nxt;
         end
         if (w_pop) begin
            r_wout <= 1'b1;
            r_dout <= w_src[r_owner];
         end else if (r_wout && READY_OUT) begin
            r_wout <= 1'b0;
         end
      end
   end

   assign WRITE_OUT = r_wout;
   assign DATA_OUT  = r_dout;
   assign OWNER     = r_owner;
   assign BUSY      = (r_state == S_BURST);

endmodule
`default_nettype wire

// File: tb/tb_burst_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_burst_rr_arbiter: directed self-checking bench for burst_rr_arbiter.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_burst_rr_arbiter;
   localparam int WIDTH  = 10;
   localparam int DATA_W = 32;

   logic                    BUS_CLK = 1'b0;
   logic                    BUS_RST = 1'b1;
   logic [WIDTH-1:0]        WRITE_REQ = '0;
   logic [WIDTH-1:0]        HOLD_REQ = '0;
   logic [WIDTH*DATA_W-1:0] DATA_IN = '0;
   logic [7:0]              BURST_LEN = 8'd1;
   logic [WIDTH-1:0]        READ_GRANT;
   logic                    READY_OUT = 1'b1;
   logic                    WRITE_OUT;
   logic [DATA_W-1:0]       DATA_OUT;
   logic [3:0]              OWNER;
   logic                    BUSY;

   burst_rr_arbiter #(.WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
      .BUS_CLK   (BUS_CLK),
      .BUS_RST   (BUS_RST),
      .WRITE_REQ (WRITE_REQ),
      .HOLD_REQ  (HOLD_REQ),
      .DATA_IN   (DATA_IN),
      .BURST_LEN (BURST_LEN),
      .READ_GRANT(READ_GRANT),
      .READY_OUT (READY_OUT),
      .WRITE_OUT (WRITE_OUT),
      .DATA_OUT  (DATA_OUT),
      .OWNER     (OWNER),
      .BUSY      (BUSY)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [WIDTH-1:0]  gl [64];
   logic [3:0]        ol [64];
   logic              wl [64];
   logic [DATA_W-1:0] dl [64];
   logic              bl [64];
   logic [DATA_W-1:0] acc_q [$];

   logic [DATA_W-1:0] src_val  [WIDTH];
   int                src_left [WIDTH];
   logic              src_en   [WIDTH];

   task automatic drive();
      for (int i = 0; i < WIDTH; i++) begin
         WRITE_REQ[i] = src_en[i] && (src_left[i] != 0);
         DATA_IN[i*DATA_W +: DATA_W] = src_val[i];
      end
   endtask

   // One clock: sample pre-edge outputs, then let the sources pop on grant.
   task automatic step();
      logic [WIDTH-1:0] g;
      drive();
      #1;
      g = READ_GRANT;
      if (cyc < 64) begin
         gl[cyc] = g; ol[cyc] = OWNER; wl[cyc] = WRITE_OUT;
         dl[cyc] = DATA_OUT; bl[cyc] = BUSY;
      end
      if (WRITE_OUT && READY_OUT && !BUS_RST) acc_q.push_back(DATA_OUT);
      @(posedge BUS_CLK);
      #1;
      for (int i = 0; i < WIDTH; i++) begin
         if (g[i]) begin
            src_val[i]  = src_val[i] + 1;
            src_left[i] = src_left[i] - 1;
         end
      end
      cyc++;
   endtask

   task automatic src_set(input int i, input logic [DATA_W-1:0] base, input int n);
      src_val[i] = base; src_left[i] = n; src_en[i] = 1'b1;
   endtask

   task automatic apply_reset();
      BUS_RST = 1'b1; HOLD_REQ = '0; READY_OUT = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         src_en[i] = 1'b0; src_left[i] = 0; src_val[i] = '0;
      end
      step();
      step();
      BUS_RST = 1'b0;
      cyc = 0;
      acc_q.delete();
   endtask

   task automatic test_reset();
      apply_reset();
      step();
      if (gl[0] !== '0) begin errors++; $display("FAIL reset_grant got %b want 0", gl[0]); end
      checks++;
      if (wl[0] !== 1'b0) begin errors++; $display("FAIL reset_wout got %b want 0", wl[0]); end
      checks++;
      if (dl[0] !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", dl[0]); end
      checks++;
      if (ol[0] !== 4'd9) begin errors++; $display("FAIL reset_owner got %0d want 9", ol[0]); end
      checks++;
      if (bl[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bl[0]); end
      checks++;
   endtask

   task automatic test_single_burst();
      logic [WIDTH-1:0]  exp;
      logic [DATA_W-1:0] got;
      int                bad_owner;
      apply_reset();
      BURST_LEN = 8'd4;
      src_set(3, 32'h100, 8);
      for (int c = 0; c < 12; c++) step();
      for (int c = 0; c < 11; c++) begin
         exp = '0;
         if ((c >= 1 && c <= 4) || (c >= 6 && c <= 9)) exp[3] = 1'b1;
         if (gl[c] !== exp) begin errors++; $display("FAIL single_grant c%0d got %b want %b", c, gl[c], exp); end
         checks++;
      end
      bad_owner = 0;
      for (int c = 1; c < 12; c++) if (ol[c] !== 4'd3) bad_owner++;
      if (bad_owner != 0) begin errors++; $display("FAIL single_owner cycles_not_3 got %0d want 0", bad_owner); end
      checks++;
      if (acc_q.size() != 8) begin errors++; $display("FAIL single_count got %0d want 8", acc_q.size()); end
      checks++;
      for (int k = 0; k < 8; k++) begin
         got = (k < acc_q.size()) ? acc_q[k] : 32'hDEAD_DEAD;
         if (got !== 32'h100 + 32'(k)) begin errors++; $display("FAIL single_data w%0d got %h want %h", k, got, 32'h100 + 32'(k)); end
         checks++;
      end
   endtask

   task automatic test_round_robin();
      logic [WIDTH-1:0]  exp;
      logic [DATA_W-1:0] got;
      logic [DATA_W-1:0] want;
      int                pops;
      apply_reset();
      BURST_LEN = 8'd2;
      for (int i = 0; i < WIDTH; i++) src_set(i, 32'(i) << 12, 100);
      for (int c = 0; c < 33; c++) step();
      pops = 0;
      for (int c = 0; c < 33; c++) begin
         exp = '0;
         if ((c % 3) != 0) exp[(c / 3) % WIDTH] = 1'b1;
         if (gl[c] !== exp) begin errors++; $display("FAIL rr_grant c%0d got %b want %b", c, gl[c], exp); end
         checks++;
         if (c < 30) pops += $countones(gl[c]);
      end
      if (pops != 20) begin errors++; $display("FAIL rr_words_in_30 got %0d want 20", pops); end
      checks++;
      for (int m = 0; m < 20; m++) begin
         got  = (m < acc_q.size()) ? acc_q[m] : 32'hDEAD_DEAD;
         want = (32'(m / 2) << 12) + 32'(m % 2);
         if (got !== want) begin errors++; $display("FAIL rr_data w%0d got %h want %h", m, got, want); end
         checks++;
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0]  exp;
      logic [DATA_W-1:0] got;
      logic [8:0]        rdy;
      apply_reset();
      BURST_LEN = 8'd4;
      src_set(5, 32'h500, 4);
      rdy = 9'b1_1110_0111;
      for (int c = 0; c < 9; c++) begin
         READY_OUT = rdy[c];
         step();
      end
      READY_OUT = 1'b1;
      for (int c = 0; c < 9; c++) begin
         exp = '0;
         if (c == 1 || c == 2 || c == 5 || c == 6) exp[5] = 1'b1;
         if (gl[c] !== exp) begin errors++; $display("FAIL bp_grant c%0d got %b want %b", c, gl[c], exp); end
         checks++;
      end
      for (int c = 3; c < 5; c++) begin
         if (wl[c] !== 1'b1 || dl[c] !== 32'h501) begin
            errors++; $display("FAIL bp_stall c%0d got wout=%b data=%h want wout=1 data=00000501", c, wl[c], dl[c]);
         end
         checks++;
      end
      if (acc_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", acc_q.size()); end
      checks++;
      for (int k = 0; k < 4; k++) begin
         got = (k < acc_q.size()) ? acc_q[k] : 32'hDEAD_DEAD;
         if (got !== 32'h500 + 32'(k)) begin errors++; $display("FAIL bp_data w%0d got %h want %h", k, got, 32'h500 + 32'(k)); end
         checks++;
      end
   endtask

   task automatic test_hold();
      logic [WIDTH-1:0]  exp;
      logic [DATA_W-1:0] got;
      logic [DATA_W-1:0] want;
      apply_reset();
      BURST_LEN = 8'd1;
      HOLD_REQ  = '0;
      HOLD_REQ[2] = 1'b1;
      src_set(2, 32'h200, 6);
      src_set(4, 32'h400, 2);
      for (int c = 0; c < 19; c++) begin
         src_en[2] = !(c >= 4 && c <= 6);
         if (c == 12) HOLD_REQ[2] = 1'b0;
         step();
      end
      for (int c = 0; c < 19; c++) begin
         exp = '0;
         if ((c >= 1 && c <= 3) || (c >= 7 && c <= 9)) exp[2] = 1'b1;
         if (c == 14 || c == 16) exp[4] = 1'b1;
         if (gl[c] !== exp) begin errors++; $display("FAIL hold_grant c%0d got %b want %b", c, gl[c], exp); end
         checks++;
      end
      if (ol[12] !== 4'd2) begin errors++; $display("FAIL hold_owner got %0d want 2", ol[12]); end
      checks++;
      for (int k = 0; k < 8; k++) begin
         got  = (k < acc_q.size()) ? acc_q[k] : 32'hDEAD_DEAD;
         want = (k < 6) ? 32'h200 + 32'(k) : 32'h400 + 32'(k - 6);
         if (got !== want) begin errors++; $display("FAIL hold_data w%0d got %h want %h", k, got, want); end
         checks++;
      end
   endtask

   task automatic test_len_zero();
      logic [WIDTH-1:0]  exp;
      logic [DATA_W-1:0] got;
      apply_reset();
      BURST_LEN = 8'd0;
      src_set(7, 32'h700, 3);
      for (int c = 0; c < 8; c++) step();
      for (int c = 0; c < 8; c++) begin
         exp = '0;
         if (c == 1 || c == 3 || c == 5) exp[7] = 1'b1;
         if (gl[c] !== exp) begin errors++; $display("FAIL len0_grant c%0d got %b want %b", c, gl[c], exp); end
         checks++;
      end
      for (int k = 0; k < 3; k++) begin
         got = (k < acc_q.size()) ? acc_q[k] : 32'hDEAD_DEAD;
         if (got !== 32'h700 + 32'(k)) begin errors++; $display("FAIL len0_data w%0d got %h want %h", k, got, 32'h700 + 32'(k)); end
         checks++;
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [WIDTH-1:0] exp;
      apply_reset();
      BURST_LEN = 8'd4;
      src_set(6, 32'h600, 10);
      step();
      step();
      BUS_RST = 1'b1;
      step();
      BUS_RST = 1'b0;
      src_set(1, 32'h100, 5);
      step();
      step();
      exp = '0; exp[6] = 1'b1;
      if (gl[1] !== exp) begin errors++; $display("FAIL rstmid_first_grant got %b want %b", gl[1], exp); end
      checks++;
      if (gl[2] !== '0) begin errors++; $display("FAIL rstmid_grant_in_reset got %b want 0", gl[2]); end
      checks++;
      if (wl[3] !== 1'b0 || dl[3] !== '0) begin
         errors++; $display("FAIL rstmid_out got wout=%b data=%h want wout=0 data=0", wl[3], dl[3]);
      end
      checks++;
      if (ol[3] !== 4'd9 || gl[3] !== '0) begin
         errors++; $display("FAIL rstmid_owner got owner=%0d grant=%b want owner=9 grant=0", ol[3], gl[3]);
      end
      checks++;
      exp = '0; exp[1] = 1'b1;
      if (gl[4] !== exp || ol[4] !== 4'd1) begin
         errors++; $display("FAIL rstmid_regrant got grant=%b owner=%0d want grant=%b owner=1", gl[4], ol[4], exp);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_backpressure();
      test_hold();
      test_len_zero();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
